// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU opcodes, forwarding selects, iterative-unit state.
// Build option EX_DIV_EN turns DIVU/REMU into multi-cycle restoring-divide operations.
package ex_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_multicycle(input alu_op_e op);
    logic mc;
    case (op)
      OP_MUL: mc = 1'b1;
`ifdef EX_DIV_EN
      OP_DIVU, OP_REMU: mc = 1'b1;
`endif
      default: mc = 1'b0;
    endcase
    return mc;
  endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// ex_muldiv_iter: iterative shift-add multiplier (and restoring divider under EX_DIV_EN).
// One step per unstalled cycle; done flags the last step, whose result is presented combinationally.
module ex_muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic            flush,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  md_state_e       state_r;
  logic [CW-1:0]   cnt_r;
  alu_op_e         op_r;
  logic [XLEN-1:0] acc_r, opa_r, opb_r;
  logic [XLEN-1:0] acc_nx_s, opa_nx_s, opb_nx_s;
`ifdef EX_DIV_EN
  logic [XLEN:0]   rem_sh_s;
  logic [XLEN-1:0] diff_s;
`endif

  assign busy = (state_r == ST_BUSY);
  assign done = busy && (cnt_r == CW'(XLEN - 1));

  // Next-step datapath: acc is product/remainder, opa is multiplicand/quotient, opb multiplier/divisor
  always_comb begin
    acc_nx_s = acc_r;
    opa_nx_s = {opa_r[XLEN-2:0], 1'b0};
    opb_nx_s = {1'b0, opb_r[XLEN-1:1]};
`ifdef EX_DIV_EN
    rem_sh_s = {acc_r, opa_r[XLEN-1]};
    diff_s   = rem_sh_s[XLEN-1:0] - opb_r;
    if ((op_r == OP_DIVU) || (op_r == OP_REMU)) begin
      opb_nx_s = opb_r;
      if (rem_sh_s >= {1'b0, opb_r}) begin
        acc_nx_s = diff_s;
        opa_nx_s = {opa_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nx_s = rem_sh_s[XLEN-1:0];
        opa_nx_s = {opa_r[XLEN-2:0], 1'b0};
      end
    end else if (opb_r[0]) begin
      acc_nx_s = acc_r + opa_r;
    end else begin
      acc_nx_s = acc_r;
    end
`else
    if (opb_r[0]) begin
      acc_nx_s = acc_r + opa_r;
    end else begin
      acc_nx_s = acc_r;
    end
`endif
  end

  // Result selection for the final step
  always_comb begin
`ifdef EX_DIV_EN
    case (op_r)
      OP_DIVU: result = opa_nx_s;
      default: result = acc_nx_s;
    endcase
`else
    if (op_r == OP_MUL) begin
      result = acc_nx_s;
    end else begin
      result = {XLEN{1'b0}};
    end
`endif
  end

  // IDLE/BUSY sequencer with step counter and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      op_r    <= OP_ADD;
      acc_r   <= {XLEN{1'b0}};
      opa_r   <= {XLEN{1'b0}};
      opb_r   <= {XLEN{1'b0}};
    end else if (flush) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else if (!stall) begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_BUSY;
            cnt_r   <= {CW{1'b0}};
            op_r    <= op;
            acc_r   <= {XLEN{1'b0}};
            opa_r   <= a;
            opb_r   <= b;
          end
        end
        ST_BUSY: begin
          acc_r <= acc_nx_s;
          opa_r <= opa_nx_s;
          opb_r <= opb_nx_s;
          if (done) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL (DIVU/REMU with EX_DIV_EN),
// and the EX/MEM pipeline register. ex_busy holds the upstream stages while the iterator runs.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_ex_valid,
  input  alu_op_e         id_ex_aluop,
  input  logic            id_ex_alusrc,
  input  logic [XLEN-1:0] id_ex_rs1_data,
  input  logic [XLEN-1:0] id_ex_rs2_data,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic [4:0]      id_ex_rd,
  input  logic            id_ex_regwrite,
  input  logic            id_ex_memread,
  input  logic            id_ex_memwrite,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] ex_mem_fwd_data,
  input  logic [XLEN-1:0] mem_wb_fwd_data,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_busy,
  output logic            ex_mem_valid,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_store_data,
  output logic [4:0]      ex_mem_rd,
  output logic            ex_mem_regwrite,
  output logic            ex_mem_memread,
  output logic            ex_mem_memwrite
);
  localparam int SHW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
    logic [XLEN-1:0] v;
    case (fwd_sel_e'(sel))
      FWD_MEM: v = mem;
      FWD_WB:  v = wb;
      default: v = rf;
    endcase
    return v;
  endfunction

  logic [XLEN-1:0] opa_s, opb_s, store_s, alu_s, md_result_s;
  logic [SHW-1:0]  shamt_s;
  logic            mc_s, start_s, md_busy_s, md_done_s;
  logic [XLEN-1:0] lat_store_r;
  logic [4:0]      lat_rd_r;
  logic            lat_regwrite_r, lat_memread_r, lat_memwrite_r;

  assign opa_s   = fwd_mux(forwardA, id_ex_rs1_data, ex_mem_fwd_data, mem_wb_fwd_data);
  assign store_s = fwd_mux(forwardB, id_ex_rs2_data, ex_mem_fwd_data, mem_wb_fwd_data);
  assign opb_s   = id_ex_alusrc ? id_ex_imm : store_s;
  assign shamt_s = opb_s[SHW-1:0];
  assign mc_s    = id_ex_valid && is_multicycle(id_ex_aluop);
  assign start_s = !md_busy_s && mc_s && !stall && !flush;

  // Single-cycle ALU; multi-cycle opcodes are produced by the iterator
  always_comb begin
    case (id_ex_aluop)
      OP_ADD:  alu_s = opa_s + opb_s;
      OP_SUB:  alu_s = opa_s - opb_s;
      OP_AND:  alu_s = opa_s & opb_s;
      OP_OR:   alu_s = opa_s | opb_s;
      OP_XOR:  alu_s = opa_s ^ opb_s;
      OP_SLL:  alu_s = opa_s << shamt_s;
      OP_SRL:  alu_s = opa_s >> shamt_s;
      OP_SRA:  alu_s = $unsigned($signed(opa_s) >>> shamt_s);
      OP_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(opa_s) < $signed(opb_s))};
      OP_SLTU: alu_s = {{(XLEN-1){1'b0}}, (opa_s < opb_s)};
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  ex_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (start_s),
    .stall  (stall),
    .flush  (flush),
    .op     (id_ex_aluop),
    .a      (opa_s),
    .b      (opb_s),
    .busy   (md_busy_s),
    .done   (md_done_s),
    .result (md_result_s)
  );

  // Upstream hold: during an iteration it drops only on the final, unstalled step
  always_comb begin
    if (rst || flush) begin
      ex_busy = 1'b0;
    end else if (md_busy_s) begin
      ex_busy = stall || !md_done_s;
    end else begin
      ex_busy = mc_s;
    end
  end

  // Control captured at iteration entry so forwarding changes cannot leak in
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_store_r    <= {XLEN{1'b0}};
      lat_rd_r       <= 5'd0;
      lat_regwrite_r <= 1'b0;
      lat_memread_r  <= 1'b0;
      lat_memwrite_r <= 1'b0;
    end else if (start_s) begin
      lat_store_r    <= store_s;
      lat_rd_r       <= id_ex_rd;
      lat_regwrite_r <= id_ex_regwrite;
      lat_memread_r  <= id_ex_memread;
      lat_memwrite_r <= id_ex_memwrite;
    end
  end

  // EX/MEM register: rst > flush > stall > normal
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_alu_result <= {XLEN{1'b0}};
      ex_mem_store_data <= {XLEN{1'b0}};
      ex_mem_rd         <= 5'd0;
      ex_mem_regwrite   <= 1'b0;
      ex_mem_memread    <= 1'b0;
      ex_mem_memwrite   <= 1'b0;
    end else if (flush) begin
      ex_mem_valid    <= 1'b0;
      ex_mem_regwrite <= 1'b0;
      ex_mem_memread  <= 1'b0;
      ex_mem_memwrite <= 1'b0;
    end else if (!stall) begin
      if (md_busy_s) begin
        ex_mem_valid      <= md_done_s;
        ex_mem_alu_result <= md_result_s;
        ex_mem_store_data <= lat_store_r;
        ex_mem_rd         <= lat_rd_r;
        ex_mem_regwrite   <= md_done_s && lat_regwrite_r;
        ex_mem_memread    <= md_done_s && lat_memread_r;
        ex_mem_memwrite   <= md_done_s && lat_memwrite_r;
      end else begin
        ex_mem_valid      <= id_ex_valid && !mc_s;
        ex_mem_alu_result <= alu_s;
        ex_mem_store_data <= store_s;
        ex_mem_rd         <= id_ex_rd;
        ex_mem_regwrite   <= id_ex_valid && !mc_s && id_ex_regwrite;
        ex_mem_memread    <= id_ex_valid && !mc_s && id_ex_memread;
        ex_mem_memwrite   <= id_ex_valid && !mc_s && id_ex_memwrite;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed forwarding/shift cases, randomized ALU traffic,
// and a table of multi-cycle scenarios (plain, flush, stall) checked against a cycle-count model.
module tb_ex_stage;
  import ex_pkg::*;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ex_valid, id_ex_alusrc, id_ex_regwrite, id_ex_memread, id_ex_memwrite;
  alu_op_e     id_ex_aluop;
  logic [31:0] id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, ex_mem_fwd_data, mem_wb_fwd_data;
  logic [4:0]  id_ex_rd;
  logic [1:0]  forwardA, forwardB;
  logic        stall, flush;
  logic        ex_busy, ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0]  ex_mem_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_ex_valid(id_ex_valid), .id_ex_aluop(id_ex_aluop),
    .id_ex_alusrc(id_ex_alusrc), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite),
    .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite), .forwardA(forwardA),
    .forwardB(forwardB), .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_fwd_data(mem_wb_fwd_data),
    .stall(stall), .flush(flush), .ex_busy(ex_busy), .ex_mem_valid(ex_mem_valid),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite)
  );

  // Reference arithmetic straight from the opcode definitions
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] p;
    int n;
    n = int'(b % 32'd32);
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << n;
      6: r = a >> n;
      7: begin r = a >> n; if (a[31]) r = r | ~(32'hFFFF_FFFF >> n); end
      8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: r = (a < b) ? 32'd1 : 32'd0;
      10: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
`ifdef EX_DIV_EN
      11: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      12: r = (b == 32'd0) ? a : a % b;
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] mem, input logic [31:0] wb);
    if (sel == 2'b10) return mem;
    if (sel == 2'b01) return wb;
    return rf;
  endfunction

  task automatic drive_idle();
    id_ex_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    id_ex_regwrite = 1'b0; id_ex_memread = 1'b0; id_ex_memwrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_ex_valid = 1'b1; id_ex_aluop = OP_MUL; id_ex_alusrc = 1'b0;
    id_ex_rs1_data = $urandom; id_ex_rs2_data = $urandom; id_ex_imm = $urandom;
    id_ex_rd = 5'd9; id_ex_regwrite = 1'b1; id_ex_memread = 1'b1; id_ex_memwrite = 1'b1;
    forwardA = 2'b00; forwardB = 2'b00; ex_mem_fwd_data = $urandom; mem_wb_fwd_data = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000",
                        {ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite});
    end
    n_cmp++;
    if ({ex_mem_alu_result, ex_mem_store_data, ex_mem_rd} !== 69'd0) begin
      n_err++; $display("FAIL reset_data: got %h/%h/%0d want 0", ex_mem_alu_result, ex_mem_store_data, ex_mem_rd);
    end
    n_cmp++;
    if (ex_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", ex_busy); end
    @(posedge clk); #1;
    rst = 1'b0; drive_idle();
    @(negedge clk);
    n_cmp++;
    if (ex_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", ex_busy); end
    @(posedge clk); #1;
    n_cmp++;
    if (ex_mem_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", ex_mem_valid); end
  endtask

  task automatic test_forwarding();
    // ADD with rs1 forwarded from EX/MEM
    drive_idle();
    id_ex_valid = 1'b1; id_ex_aluop = OP_ADD; id_ex_alusrc = 1'b0;
    id_ex_rs1_data = 32'd1000; id_ex_rs2_data = 32'd7; forwardA = 2'b10; forwardB = 2'b00;
    ex_mem_fwd_data = 32'd5; mem_wb_fwd_data = 32'd2000; id_ex_rd = 5'd3; id_ex_regwrite = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (ex_mem_alu_result !== 32'd12 || ex_mem_valid !== 1'b1 || ex_mem_rd !== 5'd3) begin
      n_err++; $display("FAIL fwd_add: got %0d v=%b rd=%0d want 12 v=1 rd=3", ex_mem_alu_result, ex_mem_valid, ex_mem_rd);
    end
    // forwardB=11 must fall back to the register file; SRA uses only amt[4:0]
    id_ex_aluop = OP_SRA; id_ex_rs1_data = 32'h8000_0000; id_ex_rs2_data = 32'd35;
    forwardA = 2'b00; forwardB = 2'b11; ex_mem_fwd_data = 32'd1; mem_wb_fwd_data = 32'd2;
    @(posedge clk); #1;
    n_cmp++;
    if (ex_mem_alu_result !== 32'hF000_0000 || ex_mem_store_data !== 32'd35) begin
      n_err++; $display("FAIL fwd11_sra: got %h store %0d want f0000000 store 35", ex_mem_alu_result, ex_mem_store_data);
    end
    // Immediate operand with rs1 from MEM/WB
    id_ex_aluop = OP_SUB; id_ex_alusrc = 1'b1; id_ex_imm = 32'd10; forwardA = 2'b01;
    mem_wb_fwd_data = 32'd3;
    @(posedge clk); #1;
    n_cmp++;
    if (ex_mem_alu_result !== 32'hFFFF_FFF9) begin
      n_err++; $display("FAIL fwd_wb_imm: got %h want fffffff9", ex_mem_alu_result);
    end
    drive_idle();
  endtask

  task automatic test_alu_random();
    logic        ev, erw, emr, emw;
    logic [31:0] er, es, a, b;
    logic [4:0]  erd;
    int          op;
    ev = 1'b0; erw = 1'b0; emr = 1'b0; emw = 1'b0; er = 32'd0; es = 32'd0; erd = 5'd0;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      id_ex_aluop = alu_op_e'(4'(op));
      id_ex_valid = ($urandom_range(0, 5) != 0);
      id_ex_alusrc = 1'($urandom_range(0, 1));
      id_ex_rs1_data = $urandom; id_ex_rs2_data = $urandom; id_ex_imm = $urandom;
      if (i % 9 == 0) id_ex_rs1_data = 32'h8000_0000;
      ex_mem_fwd_data = $urandom; mem_wb_fwd_data = $urandom;
      forwardA = 2'($urandom_range(0, 3)); forwardB = 2'($urandom_range(0, 3));
      id_ex_rd = 5'($urandom_range(0, 31));
      id_ex_regwrite = 1'($urandom_range(0, 1)); id_ex_memread = 1'($urandom_range(0, 1));
      id_ex_memwrite = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 6) == 0);
      a = ref_fwd(forwardA, id_ex_rs1_data, ex_mem_fwd_data, mem_wb_fwd_data);
      es = stall ? es : ref_fwd(forwardB, id_ex_rs2_data, ex_mem_fwd_data, mem_wb_fwd_data);
      b = id_ex_alusrc ? id_ex_imm : ref_fwd(forwardB, id_ex_rs2_data, ex_mem_fwd_data, mem_wb_fwd_data);
      if (!stall) begin
        ev = id_ex_valid; er = ref_alu(op, a, b); erd = id_ex_rd;
        erw = id_ex_valid & id_ex_regwrite; emr = id_ex_valid & id_ex_memread; emw = id_ex_valid & id_ex_memwrite;
      end
      @(negedge clk);
      n_cmp++;
      if (ex_busy !== 1'b0) begin n_err++; $display("FAIL alu_busy[%0d]: got %b want 0", i, ex_busy); end
      @(posedge clk); #1;
      n_cmp++;
      if ({ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite} !== {ev, erw, emr, emw}) begin
        n_err++; $display("FAIL alu_ctrl[%0d]: got %b want %b", i,
          {ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite}, {ev, erw, emr, emw});
      end
      if (ev) begin
        n_cmp++;
        if (ex_mem_alu_result !== er || ex_mem_store_data !== es || ex_mem_rd !== erd) begin
          n_err++; $display("FAIL alu_data[%0d] op=%0d: got %h/%h/%0d want %h/%h/%0d", i, op,
            ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, er, es, erd);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_multicycle();
    int          sc_op[9], sc_ss[9], sc_sl[9], sc_f[9];
    logic [31:0] sc_a[9], sc_b[9];
    int          nsc, act, exp_busy;
    logic [31:0] exp_r;
    logic [4:0]  rd;
    logic        exp_v, done, is_stall, is_flush;
    sc_op[0] = 10; sc_a[0] = 32'hFFFF_FFFF; sc_b[0] = 32'd3; sc_ss[0] = 0;  sc_sl[0] = 0; sc_f[0] = -1;
    sc_op[1] = 10; sc_a[1] = $urandom; sc_b[1] = $urandom;  sc_ss[1] = 0;  sc_sl[1] = 0; sc_f[1] = 10;
    sc_op[2] = 10; sc_a[2] = $urandom; sc_b[2] = $urandom;  sc_ss[2] = 5;  sc_sl[2] = 3; sc_f[2] = -1;
    sc_op[3] = 10; sc_a[3] = $urandom; sc_b[3] = $urandom;  sc_ss[3] = 32; sc_sl[3] = 2; sc_f[3] = -1;
    sc_op[4] = 10; sc_a[4] = $urandom; sc_b[4] = $urandom;  sc_ss[4] = 0;  sc_sl[4] = 0; sc_f[4] = 32;
    nsc = 5;
`ifdef EX_DIV_EN
    sc_op[5] = 11; sc_a[5] = 32'd7; sc_b[5] = 32'd0; sc_ss[5] = 0; sc_sl[5] = 0; sc_f[5] = -1;
    sc_op[6] = 12; sc_a[6] = 32'd7; sc_b[6] = 32'd0; sc_ss[6] = 0; sc_sl[6] = 0; sc_f[6] = -1;
    sc_op[7] = 11; sc_a[7] = $urandom; sc_b[7] = $urandom_range(1, 5000); sc_ss[7] = 3; sc_sl[7] = 1; sc_f[7] = -1;
    sc_op[8] = 12; sc_a[8] = $urandom; sc_b[8] = $urandom_range(1, 5000); sc_ss[8] = 0; sc_sl[8] = 0; sc_f[8] = -1;
    nsc = 9;
`endif
    for (int s = 0; s < nsc; s++) begin
      exp_r = ref_alu(sc_op[s], sc_a[s], sc_b[s]);
      rd = 5'($urandom_range(1, 31));
      id_ex_valid = 1'b1; id_ex_aluop = alu_op_e'(4'(sc_op[s])); id_ex_alusrc = 1'b0;
      forwardA = 2'b10; forwardB = 2'b01; ex_mem_fwd_data = sc_a[s]; mem_wb_fwd_data = sc_b[s];
      id_ex_rs1_data = $urandom; id_ex_rs2_data = $urandom; id_ex_rd = rd;
      id_ex_regwrite = 1'b1; id_ex_memread = 1'b0; id_ex_memwrite = 1'b0; stall = 1'b0; flush = 1'b0;
      act = 0; done = 1'b0; exp_v = 1'b0;
      for (int k = 0; k <= XLEN + 8 && !done; k++) begin
        if (k > 0) begin
          ex_mem_fwd_data = $urandom; mem_wb_fwd_data = $urandom;
          stall = (k >= sc_ss[s]) && (k < sc_ss[s] + sc_sl[s]);
          flush = (k == sc_f[s]);
        end
        is_stall = stall; is_flush = flush;
        if (!is_stall && !is_flush) act++;
        exp_busy = is_flush ? 0 : (is_stall ? 1 : ((act <= XLEN) ? 1 : 0));
        @(negedge clk);
        n_cmp++;
        if (ex_busy !== 1'(exp_busy)) begin
          n_err++; $display("FAIL mc%0d_busy k=%0d: got %b want %0d", s, k, ex_busy, exp_busy);
        end
        @(posedge clk); #1;
        if (is_flush) begin
          exp_v = 1'b0; done = 1'b1;
        end else if (!is_stall) begin
          exp_v = (act == XLEN + 1);
          done = exp_v;
        end
        n_cmp++;
        if (ex_mem_valid !== exp_v || ex_mem_regwrite !== exp_v) begin
          n_err++; $display("FAIL mc%0d_valid k=%0d: got %b/%b want %b", s, k, ex_mem_valid, ex_mem_regwrite, exp_v);
        end
        if (exp_v) begin
          n_cmp++;
          if (ex_mem_alu_result !== exp_r || ex_mem_rd !== rd) begin
            n_err++; $display("FAIL mc%0d_result: got %h rd=%0d want %h rd=%0d", s, ex_mem_alu_result, ex_mem_rd, exp_r, rd);
          end
        end
        if (done) drive_idle();
      end
      if (!done) begin
        n_cmp++; n_err++;
        $display("FAIL mc%0d_timeout: got no completion want completion within %0d cycles", s, XLEN + 9);
      end
      drive_idle();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_disabled();
`ifndef EX_DIV_EN
    for (int op = 11; op <= 12; op++) begin
      id_ex_valid = 1'b1; id_ex_aluop = alu_op_e'(4'(op)); id_ex_alusrc = 1'b0;
      forwardA = 2'b00; forwardB = 2'b00; id_ex_rs1_data = 32'd7; id_ex_rs2_data = 32'd0;
      id_ex_regwrite = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ex_busy !== 1'b0) begin n_err++; $display("FAIL nodiv_busy op=%0d: got %b want 0", op, ex_busy); end
      @(posedge clk); #1;
      n_cmp++;
      if (ex_mem_valid !== 1'b1 || ex_mem_alu_result !== 32'd0) begin
        n_err++; $display("FAIL nodiv_result op=%0d: got v=%b %h want v=1 0", op, ex_mem_valid, ex_mem_alu_result);
      end
    end
    drive_idle();
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    // Stalled MUL in IDLE: busy passes through, nothing starts, EX/MEM holds its bubble
    id_ex_valid = 1'b1; id_ex_aluop = OP_MUL; id_ex_alusrc = 1'b0; forwardA = 2'b00; forwardB = 2'b00;
    id_ex_rs1_data = $urandom; id_ex_rs2_data = $urandom; id_ex_regwrite = 1'b1; stall = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ex_busy !== 1'b1) begin n_err++; $display("FAIL idle_stall_busy: got %b want 1", ex_busy); end
    @(posedge clk); #1;
    stall = 1'b0; flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ex_busy !== 1'b0) begin n_err++; $display("FAIL idle_flush_busy: got %b want 0", ex_busy); end
    @(posedge clk); #1;
    n_cmp++;
    if (ex_mem_valid !== 1'b0) begin n_err++; $display("FAIL idle_flush_bubble: got %b want 0", ex_mem_valid); end
    a = $urandom;
    flush = 1'b0; id_ex_aluop = OP_ADD; id_ex_alusrc = 1'b1; id_ex_rs1_data = a; id_ex_imm = 32'd100; id_ex_rd = 5'd17;
    @(negedge clk);
    n_cmp++;
    if (ex_busy !== 1'b0) begin n_err++; $display("FAIL add_after_flush_busy: got %b want 0", ex_busy); end
    @(posedge clk); #1;
    n_cmp++;
    if (ex_mem_valid !== 1'b1 || ex_mem_alu_result !== a + 32'd100 || ex_mem_rd !== 5'd17) begin
      n_err++; $display("FAIL add_after_flush: got v=%b %h rd=%0d want v=1 %h rd=17", ex_mem_valid, ex_mem_alu_result, ex_mem_rd, a + 32'd100);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_alu_random();
    test_multicycle();
    test_div_disabled();
    test_back_to_back();
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
